// File: rtl/uart_tx_framed.sv
// uart_tx_framed: UART transmitter with a one-entry holding register.
// Frame = start bit, DATA_BITS data bits (LSB first), optional parity bit,
// STOP_BITS stop bits. Bit timing is driven entirely by the clk_en baud tick.
//
// Ports:
//   clk        - clock, all state on rising edge
//   rst        - asynchronous active-high reset
//   data_input - word to send, captured when a write is accepted
//   wr_en      - write request, one cycle per word
//   clk_en     - baud tick, one-cycle pulse per bit period
//   tx         - serial line, idle high
//   tx_busy    - frame in progress (state other than IDLE)
//   tx_ready   - holding register empty, a write will be accepted
//   tx_done    - one-cycle pulse at end of each frame
//   overrun    - one-cycle pulse when a write is dropped
module uart_tx_framed #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_input,
    input  logic                 wr_en,
    input  logic                 clk_en,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_ready,
    output logic                 tx_done,
    output logic                 overrun
);

    localparam int unsigned IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned STOP_W = 2;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [STOP_W-1:0] STOP_END = STOP_W'(STOP_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_BITS-1:0]  hold_q, hold_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [STOP_W-1:0]     stop_cnt_q, stop_cnt_d;
    logic                  tx_d;
    logic                  busy_d;
    logic                  ready_d;
    logic                  done_d;
    logic                  overrun_d;
    logic                  take_hold;
    logic                  parity_bit;

    // Parity over the word being shifted out; odd mode inverts the XOR.
    always_comb begin
        parity_bit = ^shift_q;
        if (PARITY == 2) begin
            parity_bit = ~parity_bit;
        end
    end

    // Next-state, datapath and output logic.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx;
        ready_d    = tx_ready;
        done_d     = 1'b0;
        take_hold  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // clk_en is ignored here; a full holding register starts a frame at once.
                tx_d = 1'b1;
                if (!tx_ready) begin
                    take_hold = 1'b1;
                    shift_d   = hold_q;
                    state_d   = S_START;
                end
            end

            S_START: begin
                if (clk_en) begin
                    tx_d    = 1'b0;
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (clk_en) begin
                    tx_d       = shift_q[idx_q];
                    stop_cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_PARITY: begin
                if (clk_en) begin
                    tx_d       = parity_bit;
                    stop_cnt_d = '0;
                    state_d    = S_STOP;
                end
            end

            S_STOP: begin
                if (clk_en) begin
                    if (stop_cnt_q == STOP_END) begin
                        // Completion tick: the last stop bit has lasted a full period.
                        done_d     = 1'b1;
                        stop_cnt_d = '0;
                        if (!tx_ready) begin
                            // Back-to-back: this tick is already the next start bit.
                            take_hold = 1'b1;
                            shift_d   = hold_q;
                            idx_d     = '0;
                            tx_d      = 1'b0;
                            state_d   = S_DATA;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        tx_d       = 1'b1;
                        stop_cnt_d = stop_cnt_q + STOP_W'(1);
                    end
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        // Holding register: emptying and filling are decided on the current
        // tx_ready, so a full register is never loaded and refilled together.
        if (take_hold) begin
            ready_d = 1'b1;
        end
        if (wr_en && tx_ready) begin
            hold_d  = data_input;
            ready_d = 1'b0;
        end
        overrun_d = wr_en && !tx_ready;

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any frame and drops held data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            shift_q    <= '0;
            idx_q      <= '0;
            stop_cnt_q <= '0;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            tx_ready   <= 1'b1;
            tx_done    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            stop_cnt_q <= stop_cnt_d;
            tx         <= tx_d;
            tx_busy    <= busy_d;
            tx_ready   <= ready_d;
            tx_done    <= done_d;
            overrun    <= overrun_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Testbench for uart_tx_framed: five parameterisations side by side
// (8N1, 8E1, 8O2, 5N1, 9E1), table-driven single frames plus hand-written
// back-to-back, overrun and mid-frame reset sequences.
module tb_uart_tx_framed;

    localparam int NINST = 5;
    localparam int NVEC  = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             clk_en;
    logic [8:0]       din;
    logic [NINST-1:0] wr_en_v;
    logic [NINST-1:0] tx_v;
    logic [NINST-1:0] busy_v;
    logic [NINST-1:0] ready_v;
    logic [NINST-1:0] done_v;
    logic [NINST-1:0] ovr_v;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_framed #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .data_input(din[7:0]), .wr_en(wr_en_v[0]),
        .clk_en(clk_en), .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_ready(ready_v[0]),
        .tx_done(done_v[0]), .overrun(ovr_v[0]));

    uart_tx_framed #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .data_input(din[7:0]), .wr_en(wr_en_v[1]),
        .clk_en(clk_en), .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_ready(ready_v[1]),
        .tx_done(done_v[1]), .overrun(ovr_v[1]));

    uart_tx_framed #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_8o2 (
        .clk(clk), .rst(rst), .data_input(din[7:0]), .wr_en(wr_en_v[2]),
        .clk_en(clk_en), .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_ready(ready_v[2]),
        .tx_done(done_v[2]), .overrun(ovr_v[2]));

    uart_tx_framed #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u_5n1 (
        .clk(clk), .rst(rst), .data_input(din[4:0]), .wr_en(wr_en_v[3]),
        .clk_en(clk_en), .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_ready(ready_v[3]),
        .tx_done(done_v[3]), .overrun(ovr_v[3]));

    uart_tx_framed #(.DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) u_9e1 (
        .clk(clk), .rst(rst), .data_input(din), .wr_en(wr_en_v[4]),
        .clk_en(clk_en), .tx(tx_v[4]), .tx_busy(busy_v[4]), .tx_ready(ready_v[4]),
        .tx_done(done_v[4]), .overrun(ovr_v[4]));

    // Expected line values: bit k of exp is the tx level after the k-th tick.
    typedef struct {
        logic [2:0]  sel;
        logic [8:0]  data;
        logic [15:0] exp;
        int          len;
    } vec_t;

    vec_t vec [NVEC];

    function automatic logic bit_at(input logic [15:0] v, input int k);
        logic [15:0] s;
        s = v >> k;
        return s[0];
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // One baud tick; returns at the falling edge after the ticked rising edge.
    task automatic tick();
        repeat (2) @(negedge clk);
        clk_en = 1'b1;
        @(negedge clk);
        clk_en = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] sel, input logic [8:0] d);
        @(negedge clk);
        wr_en_v[sel] = 1'b1;
        din          = d;
        @(negedge clk);
        wr_en_v      = '0;
    endtask

    task automatic expect_ticks(input string tag, input logic [2:0] sel,
                                input logic [15:0] exp, input int from, input int to);
        for (int k = from; k < to; k++) begin
            tick();
            check($sformatf("%s_bit%0d", tag, k), tx_v[sel], bit_at(exp, k));
            check($sformatf("%s_busy%0d", tag, k), busy_v[sel], 1'b1);
            check($sformatf("%s_done_early%0d", tag, k), done_v[sel], 1'b0);
        end
    endtask

    task automatic complete(input string tag, input logic [2:0] sel,
                            input logic exp_tx, input logic exp_busy);
        tick();
        check({tag, "_done"}, done_v[sel], 1'b1);
        check({tag, "_end_tx"}, tx_v[sel], exp_tx);
        check({tag, "_end_busy"}, busy_v[sel], exp_busy);
        @(negedge clk);
        check({tag, "_done_1cyc"}, done_v[sel], 1'b0);
    endtask

    task automatic check_reset_vals(input string tag, input logic [2:0] sel);
        check({tag, "_tx"}, tx_v[sel], 1'b1);
        check({tag, "_busy"}, busy_v[sel], 1'b0);
        check({tag, "_ready"}, ready_v[sel], 1'b1);
        check({tag, "_done"}, done_v[sel], 1'b0);
        check({tag, "_ovr"}, ovr_v[sel], 1'b0);
    endtask

    initial begin
        // sel: 0=8N1 1=8E1 2=8O2 3=5N1 4=9E1; exp = {stop, parity, data, start}
        vec[0] = '{3'd0, 9'h0A5, 16'({1'b1, 8'hA5, 1'b0}), 10};
        vec[1] = '{3'd0, 9'h000, 16'({1'b1, 8'h00, 1'b0}), 10};
        vec[2] = '{3'd0, 9'h0FF, 16'({1'b1, 8'hFF, 1'b0}), 10};
        vec[3] = '{3'd1, 9'h007, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11};
        vec[4] = '{3'd1, 9'h003, 16'({1'b1, 1'b0, 8'h03, 1'b0}), 11};
        vec[5] = '{3'd2, 9'h007, 16'({2'b11, 1'b0, 8'h07, 1'b0}), 12};
        vec[6] = '{3'd2, 9'h000, 16'({2'b11, 1'b1, 8'h00, 1'b0}), 12};
        vec[7] = '{3'd3, 9'h016, 16'({1'b1, 5'h16, 1'b0}), 7};
        vec[8] = '{3'd4, 9'h1A5, 16'({1'b1, 1'b1, 9'h1A5, 1'b0}), 12};
        vec[9] = '{3'd4, 9'h100, 16'({1'b1, 1'b1, 9'h100, 1'b0}), 12};

        rst     = 1'b1;
        clk_en  = 1'b0;
        din     = '0;
        wr_en_v = '0;
        #12;
        for (int i = 0; i < NINST; i++) begin
            check_reset_vals($sformatf("rst_i%0d", i), 3'(i));
        end
        @(negedge clk);
        rst = 1'b0;

        // clk_en in IDLE must not disturb the line.
        tick();
        tick();
        check("idle_tx", tx_v[0], 1'b1);
        check("idle_busy", busy_v[0], 1'b0);

        // Single frames from the table.
        for (int i = 0; i < NVEC; i++) begin
            string t;
            t = $sformatf("v%0d", i);
            do_write(vec[i].sel, vec[i].data);
            check({t, "_ready_low"}, ready_v[vec[i].sel], 1'b0);
            check({t, "_no_ovr"}, ovr_v[vec[i].sel], 1'b0);
            @(negedge clk);
            check({t, "_ready_back"}, ready_v[vec[i].sel], 1'b1);
            check({t, "_busy_start"}, busy_v[vec[i].sel], 1'b1);
            check({t, "_idle_line"}, tx_v[vec[i].sel], 1'b1);
            expect_ticks(t, vec[i].sel, vec[i].exp, 0, vec[i].len);
            complete(t, vec[i].sel, 1'b1, 1'b0);
        end

        // Back-to-back frames 0x11 then 0x22 with no idle tick.
        do_write(3'd0, 9'h011);
        do_write(3'd0, 9'h022);
        check("b2b_held", ready_v[0], 1'b0);
        expect_ticks("b2b_f1", 3'd0, 16'({1'b1, 8'h11, 1'b0}), 0, 10);
        complete("b2b_f1", 3'd0, 1'b0, 1'b1);
        expect_ticks("b2b_f2", 3'd0, 16'({1'b1, 8'h22, 1'b0}), 1, 10);
        complete("b2b_f2", 3'd0, 1'b1, 1'b0);

        // Three writes during one frame: 0x02 held, 0x03 dropped.
        do_write(3'd0, 9'h001);
        do_write(3'd0, 9'h002);
        check("ovr_none_yet", ovr_v[0], 1'b0);
        do_write(3'd0, 9'h003);
        check("ovr_pulse", ovr_v[0], 1'b1);
        @(negedge clk);
        check("ovr_1cyc", ovr_v[0], 1'b0);
        expect_ticks("ovr_f1", 3'd0, 16'({1'b1, 8'h01, 1'b0}), 0, 10);
        complete("ovr_f1", 3'd0, 1'b0, 1'b1);
        expect_ticks("ovr_f2", 3'd0, 16'({1'b1, 8'h02, 1'b0}), 1, 10);
        complete("ovr_f2", 3'd0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("ovr_no3rd_tx%0d", k), tx_v[0], 1'b1);
            check($sformatf("ovr_no3rd_busy%0d", k), busy_v[0], 1'b0);
        end

        // Reset during data bit 3 (a 0 bit of 0xA5) with a word also held.
        do_write(3'd0, 9'h0A5);
        @(negedge clk);
        do_write(3'd0, 9'h05A);
        expect_ticks("rst_pre", 3'd0, 16'({1'b1, 8'hA5, 1'b0}), 0, 5);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("rst_async", 3'd0);
        @(negedge clk);
        rst = 1'b0;
        do_write(3'd0, 9'h03C);
        @(negedge clk);
        expect_ticks("rst_post", 3'd0, 16'({1'b1, 8'h3C, 1'b0}), 0, 10);
        complete("rst_post", 3'd0, 1'b1, 1'b0);
        tick();
        check("rst_held_dropped", busy_v[0], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
